// File: rtl/proj_fm_ring_pkg.sv
// Shared constants and types for the fragment-memory ring between the symbol
// writer and the fragment reader.
package proj_fm_ring_pkg;

   localparam int FM_RING_BUFFER_COUNT = 4;
   localparam int FM_RING_DEPTH        = 256;
   localparam int FM_DATA_BITS         = 2;
   localparam int FM_RING_FRAG_SYMS    = 32;
   localparam int FM_RING_IDX_LEN      = 10;

   typedef logic [FM_DATA_BITS-1:0] fm_sym_t;

   // Next slot in a ring of n entries, written out so non-power-of-two rings wrap correctly.
   function automatic int fm_ring_next(input int cur, input int n);
      return (cur == n - 1) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/proj_fm_ring_frag_extract.sv
// Combinational fragment window: picks FRAG_SYMS symbols from one buffer row at
// a signed start index, substituting zero for any position outside the row.
module proj_fm_frag_extract
   import proj_fm_ring_pkg::*;
#(
   parameter int DEPTH     = FM_RING_DEPTH,
   parameter int DATA_BITS = FM_DATA_BITS,
   parameter int FRAG_SYMS = FM_RING_FRAG_SYMS,
   parameter int IDX_LEN   = FM_RING_IDX_LEN
) (
   input  logic [DEPTH*DATA_BITS-1:0]     i_row,
   input  logic [IDX_LEN-1:0]             i_idx,
   output logic [FRAG_SYMS*DATA_BITS-1:0] o_frag
);

   localparam int AW = $clog2(DEPTH);

   for (genvar j = 0; j < FRAG_SYMS; j++) begin : g_sym
      logic [IDX_LEN:0] w_p;
      logic             w_in_range;

      // One extra bit keeps idx + j from wrapping back into the valid range.
      assign w_p        = {i_idx[IDX_LEN-1], i_idx} + (IDX_LEN+1)'(j);
      assign w_in_range = !w_p[IDX_LEN] && (w_p < (IDX_LEN+1)'(DEPTH));
      assign o_frag[j*DATA_BITS +: DATA_BITS] =
         w_in_range ? i_row[w_p[AW-1:0]*DATA_BITS +: DATA_BITS] : '0;
   end

endmodule

// File: rtl/proj_fm_ring.sv
// N-deep ring of symbol buffers: the writer fills whole buffers under
// back-pressure, the reader pulls padded fragments from the oldest full one.
module proj_fm_ring
   import proj_fm_ring_pkg::*;
#(
   parameter int BUFFER_COUNT = FM_RING_BUFFER_COUNT,
   parameter int DEPTH        = FM_RING_DEPTH,
   parameter int DATA_BITS    = FM_DATA_BITS,
   parameter int FRAG_SYMS    = FM_RING_FRAG_SYMS,
   parameter int IDX_LEN      = FM_RING_IDX_LEN
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush,
   input  logic                                in_valid,
   input  logic [DATA_BITS-1:0]                in_data,
   output logic                                in_ready,
   output logic                                rd_avail,
   output logic [$clog2(BUFFER_COUNT+1)-1:0]   full_cnt,
   input  logic                                rd_req,
   input  logic [IDX_LEN-1:0]                  rd_idx,
   input  logic                                rd_release,
   output logic                                out_valid,
   output logic [FRAG_SYMS*DATA_BITS-1:0]      out_frag,
   output logic                                err_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(BUFFER_COUNT);
   localparam int CW = $clog2(BUFFER_COUNT+1);

   logic [BUFFER_COUNT-1:0][DEPTH*DATA_BITS-1:0] r_mem;
   logic [BW-1:0]                  r_wbuf;
   logic [BW-1:0]                  r_rbuf;
   logic [AW-1:0]                  r_waddr;
   logic [CW-1:0]                  r_full_cnt;
   logic                           r_out_valid;
   logic [FRAG_SYMS*DATA_BITS-1:0] r_out_frag;
   logic                           r_err;

   logic                           w_wr;
   logic                           w_done;
   logic                           w_rel;
   logic                           w_rd;
   logic [DEPTH*DATA_BITS-1:0]     w_row;
   logic [FRAG_SYMS*DATA_BITS-1:0] w_frag;

   assign in_ready      = (r_full_cnt != CW'(BUFFER_COUNT));
   assign rd_avail      = (r_full_cnt != '0);
   assign full_cnt      = r_full_cnt;
   assign out_valid     = r_out_valid;
   assign out_frag      = r_out_frag;
   assign err_underflow = r_err;

   assign w_wr   = in_valid && in_ready;
   assign w_done = w_wr && (r_waddr == AW'(DEPTH-1));
   assign w_rel  = rd_release && rd_avail;
   assign w_rd   = rd_req && rd_avail;
   assign w_row  = r_mem[r_rbuf];

   proj_fm_frag_extract #(
      .DEPTH     (DEPTH),
      .DATA_BITS (DATA_BITS),
      .FRAG_SYMS (FRAG_SYMS),
      .IDX_LEN   (IDX_LEN)
   ) u_extract (
      .i_row  (w_row),
      .i_idx  (rd_idx),
      .o_frag (w_frag)
   );

   // Storage has no reset: contents are only ever read after a full rewrite.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wbuf][r_waddr*DATA_BITS +: DATA_BITS] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wbuf      <= '0;
         r_rbuf      <= '0;
         r_waddr     <= '0;
         r_full_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_frag  <= '0;
         r_err       <= 1'b0;
      end else if (flush) begin
         r_wbuf      <= '0;
         r_rbuf      <= '0;
         r_waddr     <= '0;
         r_full_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_wr)   r_waddr <= r_waddr + 1'b1;
         if (w_done) r_wbuf  <= BW'(fm_ring_next(int'(r_wbuf), BUFFER_COUNT));
         if (w_rel)  r_rbuf  <= BW'(fm_ring_next(int'(r_rbuf), BUFFER_COUNT));
         case ({w_done, w_rel})
            2'b10:   r_full_cnt <= r_full_cnt + 1'b1;
            2'b01:   r_full_cnt <= r_full_cnt - 1'b1;
            default: r_full_cnt <= r_full_cnt;
         endcase
         r_out_valid <= w_rd;
         if (w_rd) r_out_frag <= w_frag;
         if ((rd_req || rd_release) && !rd_avail) r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_proj_fm_ring.sv
// Bench for proj_fm_ring: directed sequences and a fragment table, plus random
// traffic, all checked against a queue-of-buffers reference model.
module tb_proj_fm_ring;

   localparam int BC = 4;
   localparam int D  = 256;
   localparam int FS = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [1:0]  in_data;
   logic        in_ready;
   logic        rd_avail;
   logic [2:0]  full_cnt;
   logic        rd_req;
   logic [9:0]  rd_idx;
   logic        rd_release;
   logic        out_valid;
   logic [63:0] out_frag;
   logic        err_underflow;

   int checks   = 0;
   int failures = 0;

   // Reference model: completed buffers in arrival order plus the one being filled.
   logic [511:0] q[$];
   logic [511:0] cur;
   int           cnt;
   logic         m_valid;
   logic [63:0]  m_frag;
   logic         m_err;

   typedef struct {
      logic [9:0] idx;
      int         lo;
      int         hi;
   } vec_t;
   vec_t tbl[11];

   always #5 clk = ~clk;

   proj_fm_ring dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .rd_avail      (rd_avail),
      .full_cnt      (full_cnt),
      .rd_req        (rd_req),
      .rd_idx        (rd_idx),
      .rd_release    (rd_release),
      .out_valid     (out_valid),
      .out_frag      (out_frag),
      .err_underflow (err_underflow)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_frag(input logic [511:0] b, input int idx);
      logic [63:0] f = '0;
      for (int j = 0; j < FS; j++) begin
         int p = idx + j;
         if (p >= 0 && p < D) f[j*2 +: 2] = b[p*2 +: 2];
      end
      return f;
   endfunction

   task automatic model_reset();
      q.delete();
      cnt     = 0;
      m_valid = 1'b0;
      m_frag  = '0;
      m_err   = 1'b0;
   endtask

   task automatic model_edge();
      bit avail = (q.size() != 0);
      bit rdy   = (q.size() < BC);
      if (flush) begin
         q.delete();
         cnt     = 0;
         m_valid = 1'b0;
         m_err   = 1'b0;
      end else begin
         m_valid = rd_req && avail;
         if (m_valid) m_frag = ref_frag(q[0], int'($signed(rd_idx)));
         if ((rd_req || rd_release) && !avail) m_err = 1'b1;
         if (in_valid && rdy) begin
            cur[cnt*2 +: 2] = in_data;
            cnt++;
         end
         if (rd_release && avail) void'(q.pop_front());
         if (cnt == D) begin
            q.push_back(cur);
            cnt = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".in_ready"},  64'(in_ready),      64'(q.size() < BC));
      chk({tag, ".rd_avail"},  64'(rd_avail),      64'(q.size() != 0));
      chk({tag, ".full_cnt"},  64'(full_cnt),      64'(q.size()));
      chk({tag, ".out_valid"}, 64'(out_valid),     64'(m_valid));
      chk({tag, ".err"},       64'(err_underflow), 64'(m_err));
      chk({tag, ".out_frag"},  out_frag,           m_frag);
   endtask

   task automatic step(input string tag, input logic v, input logic [1:0] d, input logic req,
                       input logic [9:0] idx, input logic rel, input logic fl);
      in_valid   = v;
      in_data    = d;
      rd_req     = req;
      rd_idx     = idx;
      rd_release = rel;
      flush      = fl;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      in_valid = 0; in_data = 0; rd_req = 0; rd_idx = 0; rd_release = 0; flush = 0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset_async");
      @(posedge clk);
      #1;
      check_all("reset_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] e;
      int          ii;

      rst_n = 1'b0;
      in_valid = 0; in_data = 0; rd_req = 0; rd_idx = 0; rd_release = 0; flush = 0;
      cur = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // First buffer with symbol i = i mod 4.
      for (int i = 0; i < D; i++) step("fill0", 1'b1, 2'(i % 4), 1'b0, 10'd0, 1'b0, 1'b0);
      chk("fill0.full_cnt_is_1", 64'(full_cnt), 64'd1);
      chk("fill0.rd_avail_is_1", 64'(rd_avail), 64'd1);

      tbl[0]  = '{10'd0,            0, 31};
      tbl[1]  = '{10'(-5),          5, 31};
      tbl[2]  = '{10'd240,          0, 15};
      tbl[3]  = '{10'd224,          0, 31};
      tbl[4]  = '{10'd225,          0, 30};
      tbl[5]  = '{10'(-31),        31, 31};
      tbl[6]  = '{10'd255,          0,  0};
      tbl[7]  = '{10'(-32),        32, -1};
      tbl[8]  = '{10'd256,         32, -1};
      tbl[9]  = '{10'd511,         32, -1};
      tbl[10] = '{10'(-512),       32, -1};
      for (int t = 0; t < 11; t++) begin
         step("tbl", 1'b0, 2'd0, 1'b1, tbl[t].idx, 1'b0, 1'b0);
         ii = int'($signed(tbl[t].idx));
         e  = '0;
         for (int j = tbl[t].lo; j <= tbl[t].hi; j++) e[j*2 +: 2] = 2'((ii + j) & 3);
         chk($sformatf("tbl%0d.valid", t), 64'(out_valid), 64'd1);
         chk($sformatf("tbl%0d.frag", t), out_frag, e);
         idle("tbl_hold");
      end

      // Fill the remaining three buffers, then hold in_valid against back-pressure.
      for (int i = 0; i < 3*D; i++) step("fill_all", 1'b1, 2'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step("blocked", 1'b1, 2'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
         chk("blocked.in_ready_low", 64'(in_ready), 64'd0);
         chk("blocked.full_cnt_4", 64'(full_cnt), 64'd4);
      end
      step("unblock", 1'b1, 2'd1, 1'b0, 10'd0, 1'b1, 1'b0);
      chk("unblock.in_ready_high", 64'(in_ready), 64'd1);
      chk("unblock.full_cnt_3", 64'(full_cnt), 64'd3);
      for (int i = 0; i < D; i++) step("refill", 1'b1, 2'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
      for (int b = 0; b < BC; b++) begin
         step("drain_rd", 1'b0, 2'd0, 1'b1, 10'($urandom_range(0, 300) - 32), 1'b0, 1'b0);
         step("drain_rel", 1'b0, 2'd0, 1'b0, 10'd0, 1'b1, 1'b0);
      end

      // Completion of buffer 1 coincides with release of buffer 0.
      step("flush_a", 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b1);
      for (int i = 0; i < 2*D - 1; i++) step("coinc_fill", 1'b1, 2'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
      step("coinc", 1'b1, 2'd3, 1'b1, 10'd0, 1'b1, 1'b0);
      chk("coinc.full_cnt_1", 64'(full_cnt), 64'd1);
      step("coinc_rd", 1'b0, 2'd0, 1'b1, 10'd7, 1'b0, 1'b0);

      // Underflow is sticky until flush.
      step("flush_b", 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b1);
      step("uflow", 1'b0, 2'd0, 1'b1, 10'd0, 1'b1, 1'b0);
      chk("uflow.err_set", 64'(err_underflow), 64'd1);
      chk("uflow.no_valid", 64'(out_valid), 64'd0);
      chk("uflow.full_cnt_0", 64'(full_cnt), 64'd0);
      idle("uflow_sticky");
      chk("uflow.err_sticky", 64'(err_underflow), 64'd1);
      step("flush_c", 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b1);
      chk("flush.err_clear", 64'(err_underflow), 64'd0);

      // Reset mid-buffer discards the partial fill.
      for (int i = 0; i < 100; i++) step("pre_rst", 1'b1, 2'($urandom), 1'b0, 10'd0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < D; i++) step("post_rst", 1'b1, 2'((i * 3) % 4), 1'b0, 10'd0, 1'b0, 1'b0);
      step("post_rst_rd", 1'b0, 2'd0, 1'b1, 10'd0, 1'b0, 1'b0);
      e = '0;
      for (int j = 0; j < FS; j++) e[j*2 +: 2] = 2'((j * 3) % 4);
      chk("post_rst.frag", out_frag, e);

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         logic [9:0] ridx;
         ridx = ($urandom % 2 == 0) ? 10'($urandom) : 10'($urandom_range(0, 300) - 32);
         step("rand", ($urandom % 4) != 0, 2'($urandom), ($urandom % 3) == 0, ridx,
              ($urandom % 150) == 0, ($urandom % 1500) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
